// File: rtl/hilo_muldiv_unit_if.sv
// rtl/hilo_muldiv_unit_if.sv - EX-stage request and committed HI/LO result bundle for the mul/div unit
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output start, op, a, b, flush, input busy, done, HI, LO);
    modport slave  (input start, op, a, b, flush, output busy, done, HI, LO);
endinterface

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative radix-2 multiply/divide unit owning the architectural HI/LO pair
module hilo_muldiv_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] HILO_RST = '0
) (
    input  logic              clk,
    input  logic              CLR,
    hilo_muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
    localparam int CW = $clog2(WIDTH);

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_neg_prod;
    logic               r_neg_rem;
    logic               r_div0;
    logic               r_busy;
    logic               r_done;

    logic               w_signed;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_sh;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_signed = ~bus.op[0];
    assign w_sa     = w_signed & bus.a[WIDTH-1];
    assign w_sb     = w_signed & bus.b[WIDTH-1];
    assign w_mag_a  = w_sa ? -bus.a : bus.a;
    assign w_mag_b  = w_sb ? -bus.b : bus.b;

    // Multiply keeps {partial product, remaining multiplier bits} in r_acc;
    // divide keeps {partial remainder, dividend bits shifting into quotient}.
    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    assign w_sh    = {r_acc, 1'b0};
    assign w_trial = w_sh[2*WIDTH:WIDTH] - {1'b0, r_opnd};

    always_comb begin
        w_step = r_acc;
        if (r_is_div) begin
            if (!w_trial[WIDTH])
                w_step = {w_trial[WIDTH-1:0], w_sh[WIDTH-1:1], 1'b1};
            else
                w_step = w_sh[2*WIDTH-1:0];
        end else begin
            if (r_acc[0])
                w_step = {w_sum, r_acc[WIDTH-1:1]};
            else
                w_step = {1'b0, r_acc[2*WIDTH-1:1]};
        end
    end

    assign w_prod = r_neg_prod ? -r_acc : r_acc;
    assign w_quo  = r_neg_prod ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (CLR) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_a        <= '0;
            r_hi       <= HILO_RST;
            r_lo       <= HILO_RST;
            r_is_div   <= 1'b0;
            r_neg_prod <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div0     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        case (bus.op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                r_state    <= S_RUN;
                                r_busy     <= 1'b1;
                                r_cnt      <= CW'(WIDTH - 1);
                                r_is_div   <= bus.op[1];
                                r_neg_prod <= w_sa ^ w_sb;
                                r_neg_rem  <= w_sa;
                                r_div0     <= bus.op[1] && (bus.b == '0);
                                r_a        <= bus.a;
                                r_acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? w_mag_a : w_mag_b)};
                                r_opnd     <= bus.op[1] ? w_mag_b : w_mag_a;
                            end
                            3'b100:  r_hi <= bus.a;
                            3'b101:  r_lo <= bus.a;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == '0)
                            r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!bus.flush) begin
                        r_done <= 1'b1;
                        // Divide-by-zero result overrides whatever the iteration produced.
                        if (r_div0) begin
                            r_hi <= r_a;
                            r_lo <= '1;
                        end else if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            {r_hi, r_lo} <= w_prod;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;
endmodule
